tl_ctrl_param: RTL and testbench

Parametrised traffic-light controller. The phase FSM, phase counter and lamp decode live in one block.
- Generalises the fixed-timing R/G/Y datapath: phase durations are parameters and are also run-time reloadable.
- Adds a distinct flashing-green phase with configurable period and count, a hold (freeze) input and an emergency all-red override.
- Sits below the intersection top level; a host or test sequencer drives the cfg port.

---
 rtl/tl_ctrl_param_pkg.sv | 22 ++
 rtl/tl_ctrl_param_timer.sv | 28 ++
 rtl/tl_ctrl_param.sv | 75 +++++++
 tb/tb_tl_ctrl_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ctrl_param_pkg.sv
// tl_ctrl_param_pkg: shared state indices, encodings and state type for the traffic-light controller
package tl_ctrl_param_pkg;
  localparam int STATE_W  = 6;
  localparam int S_INIT   = 0;
  localparam int S_G      = 1;
  localparam int S_GF     = 2;
  localparam int S_Y      = 3;
  localparam int S_R      = 4;
  localparam int S_ALLRED = 5;
  localparam logic [1:0] SEL_G    = 2'd0;
  localparam logic [1:0] SEL_Y    = 2'd1;
  localparam logic [1:0] SEL_R    = 2'd2;
  localparam logic [1:0] SEL_INIT = 2'd3;
  typedef enum logic [2:0] {
    ST_INIT   = 3'(S_INIT),
    ST_G      = 3'(S_G),
    ST_GF     = 3'(S_GF),
    ST_Y      = 3'(S_Y),
    ST_R      = 3'(S_R),
    ST_ALLRED = 3'(S_ALLRED)
  } state_t;
endpackage

// File: rtl/tl_ctrl_param_timer.sv
// tl_phase_timer: per-phase counter with duration latch, hold gating and end-of-phase compare
module tl_phase_timer #(
  parameter int CNT_W = 11,
  parameter int D_RST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             hold,
  input  logic [CNT_W-1:0] dur_next,
  output logic [CNT_W-1:0] cnt,
  output logic             phase_done
);
  logic [CNT_W-1:0] dur;
  logic             en;
  assign en         = run & ~hold;
  assign phase_done = en & (cnt == dur - 1'b1);
  // restart and latch a fresh duration on phase entry; a zero duration runs as one cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      dur <= CNT_W'((D_RST == 0) ? 1 : D_RST);
    end else if (load) begin
      cnt <= '0;
      dur <= (dur_next == '0) ? CNT_W'(1) : dur_next;
    end else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tl_ctrl_param.sv
// tl_ctrl_param: parametrised R/G/flash-G/Y controller with hold, emergency all-red and reloadable durations
module tl_ctrl_param
  import tl_ctrl_param_pkg::*;
#(
  parameter int CNT_W      = 11,
  parameter int T_INIT     = 1024,
  parameter int T_G        = 512,
  parameter int T_Y        = 512,
  parameter int T_R        = 1024,
  parameter int FLASH_HALF = 128,
  parameter int FLASH_N    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [CNT_W-1:0]   cfg_data,
  input  logic               hold,
  input  logic               emg,
  output logic [STATE_W-1:0] state,
  output logic               phase_done,
  output logic               R,
  output logic               G,
  output logic               Y
);
  localparam int GF_LEN = 2 * FLASH_N * FLASH_HALF;
  state_t                 st, st_next;
  logic [3:0][CNT_W-1:0]  dreg;
  logic [CNT_W-1:0]       cnt, dur_next;
  logic                   flash, run, load, half_end;
  assign run      = st != ST_ALLRED;
  assign load     = emg | (st_next != st);
  assign half_end = (cnt % CNT_W'(FLASH_HALF)) == CNT_W'(FLASH_HALF - 1);
  assign dur_next = (st_next == ST_G)  ? dreg[SEL_G] :
                    (st_next == ST_GF) ? CNT_W'(GF_LEN) :
                    (st_next == ST_Y)  ? dreg[SEL_Y] :
                    (st_next == ST_R)  ? dreg[SEL_R] : dreg[SEL_INIT];
  // host-writable duration registers, defaults restored on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) dreg <= {CNT_W'(T_INIT), CNT_W'(T_R), CNT_W'(T_Y), CNT_W'(T_G)};
    else if (cfg_we) dreg[cfg_sel] <= cfg_data;
  // phase state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= ST_INIT;
    else st <= st_next;
  // emergency wins, ALLRED always exits to red, otherwise advance at the end of a timed phase
  always_comb begin
    st_next = st;
    if (emg) st_next = ST_ALLRED;
    else if (st == ST_ALLRED) st_next = ST_R;
    else if (phase_done)
      st_next = (st == ST_INIT || st == ST_R) ? ST_G :
                (st == ST_G) ? ST_GF :
                (st == ST_GF) ? ST_Y : ST_R;
  end
  // flash bit starts dark on every entry and toggles at each half-period boundary in GF
  always_ff @(posedge clk or negedge reset)
    if (!reset) flash <= 1'b0;
    else if (load) flash <= 1'b0;
    else if (st == ST_GF && !hold && half_end) flash <= ~flash;
  tl_phase_timer #(.CNT_W(CNT_W), .D_RST(T_INIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .run       (run),
    .hold      (hold),
    .dur_next  (dur_next),
    .cnt       (cnt),
    .phase_done(phase_done)
  );
  assign state = STATE_W'(1) << st;
  assign G     = (st == ST_INIT) | (st == ST_G) | ((st == ST_GF) & flash);
  assign Y     = st == ST_Y;
  assign R     = (st == ST_R) | (st == ST_ALLRED);
endmodule

// File: tb/tb_tl_ctrl_param.sv
// tb_tl_ctrl_param: scenario and randomized lockstep checks of tl_ctrl_param against a phase-level model
module tb_tl_ctrl_param;
  localparam int CW = 6, TI = 8, TG = 4, TY = 3, TR = 5, FH = 2, FN = 2;
  localparam int P_INIT = 0, P_G = 1, P_GF = 2, P_Y = 3, P_R = 4, P_AR = 5;
  logic          clk = 1'b0, reset = 1'b0, cfg_we = 1'b0, hold = 1'b0, emg = 1'b0;
  logic [1:0]    cfg_sel = 2'd0;
  logic [CW-1:0] cfg_data = '0;
  logic [5:0]    state;
  logic          phase_done, r_l, g_l, y_l;
  int            nchk = 0, nfail = 0;
  int            m_st, m_cnt, m_dur;
  int            m_reg[4];

  tl_ctrl_param #(.CNT_W(CW), .T_INIT(TI), .T_G(TG), .T_Y(TY), .T_R(TR),
                  .FLASH_HALF(FH), .FLASH_N(FN)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .hold(hold), .emg(emg), .state(state), .phase_done(phase_done),
    .R(r_l), .G(g_l), .Y(y_l)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int dur_for(int s);
    case (s)
      P_G:     return eff(m_reg[0]);
      P_GF:    return 2 * FN * FH;
      P_Y:     return eff(m_reg[1]);
      P_R:     return eff(m_reg[2]);
      default: return eff(m_reg[3]);
    endcase
  endfunction

  function automatic logic [9:0] exp_vec();
    logic pd, fl;
    pd = !hold && m_st != P_AR && m_cnt == m_dur - 1;
    fl = m_st == P_GF && ((m_cnt / FH) % 2 == 1);
    return {6'(1 << m_st), pd, (m_st == P_R || m_st == P_AR),
            (m_st == P_INIT || m_st == P_G || fl), (m_st == P_Y)};
  endfunction

  task automatic m_reset();
    m_st = P_INIT; m_cnt = 0; m_dur = TI;
    m_reg = '{TG, TY, TR, TI};
  endtask

  task automatic m_step();
    int nx;
    if (emg) begin
      m_st = P_AR; m_cnt = 0; m_dur = 1;
    end else if (m_st == P_AR) begin
      m_st = P_R; m_cnt = 0; m_dur = eff(m_reg[2]);
    end else if (!hold) begin
      if (m_cnt == m_dur - 1) begin
        nx = (m_st == P_G) ? P_GF : (m_st == P_GF) ? P_Y : (m_st == P_Y) ? P_R : P_G;
        m_st = nx; m_cnt = 0; m_dur = dur_for(nx);
      end else m_cnt++;
    end
    if (cfg_we) m_reg[cfg_sel] = int'(cfg_data);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cfg_we = 0; hold = 0; emg = 0;
    reset = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic wait_state(input int b, output bit ok);
    int n = 0;
    while (!state[b] && n < 100) begin tick(); n++; end
    ok = state[b];
  endtask

  task automatic test_reset();
    m_reset();
    #1;
    nchk++;
    if ({state, phase_done, r_l, g_l, y_l} !== 10'b000001_0_010) begin
      nfail++; $display("FAIL reset_now: got %b required %b", {state, phase_done, r_l, g_l, y_l}, 10'b0000010010);
    end
    @(posedge clk); #1;
    nchk++;
    if ({state, phase_done, r_l, g_l, y_l} !== 10'b000001_0_010) begin
      nfail++; $display("FAIL reset_held: got %b required %b", {state, phase_done, r_l, g_l, y_l}, 10'b0000010010);
    end
  endtask

  task automatic test_sequence();
    logic [7:0]  gpat = '0;
    logic [35:0] pdm = '0;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      #1;
      nchk++;
      if ({state, phase_done, r_l, g_l, y_l} !== exp_vec()) begin
        nfail++; $display("FAIL seq cyc %0d: got %b required %b", c, {state, phase_done, r_l, g_l, y_l}, exp_vec());
      end
      if (c >= 12 && c < 20) gpat[c-12] = g_l;
      pdm[c] = phase_done;
      tick();
    end
    nchk++;
    if (gpat !== 8'b11001100) begin
      nfail++; $display("FAIL flash_pattern: got %b required %b", gpat, 8'b11001100);
    end
    nchk++;
    if (pdm[27:0] !== 28'((1 << 7) | (1 << 11) | (1 << 19) | (1 << 22) | (1 << 27))) begin
      nfail++; $display("FAIL done_cycles: got %b required %b", pdm[27:0], 28'((1 << 7) | (1 << 11) | (1 << 19) | (1 << 22) | (1 << 27)));
    end
  endtask

  task automatic test_cfg_write();
    bit ok;
    int n;
    do_reset();
    wait_state(P_G, ok);
    cfg_we = 1; cfg_sel = 2'd1; cfg_data = CW'(6); tick(); cfg_we = 0;
    n = 1;
    while (state[P_G] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 4) begin nfail++; $display("FAIL cfg_g_len: got %0d required %0d", n, 4); end
    wait_state(P_Y, ok);
    n = 0;
    while (state[P_Y] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 6) begin nfail++; $display("FAIL cfg_y_new: got %0d required %0d", n, 6); end
    cfg_we = 1; cfg_sel = 2'd1; cfg_data = CW'(3); tick(); cfg_we = 0;
    n = 0;
    while (!(state[P_GF] && phase_done) && n < 100) begin n++; tick(); end
    cfg_we = 1; cfg_sel = 2'd1; cfg_data = CW'(9); tick(); cfg_we = 0;
    n = 0;
    while (state[P_Y] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 3) begin nfail++; $display("FAIL cfg_entry_write: got %0d required %0d", n, 3); end
    wait_state(P_Y, ok);
    n = 0;
    while (state[P_Y] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 9) begin nfail++; $display("FAIL cfg_y_next: got %0d required %0d", n, 9); end
  endtask

  task automatic test_hold();
    bit ok;
    int n = 0, bad = 0;
    do_reset();
    wait_state(P_R, ok);
    while (state[P_R] && n < 40) begin
      hold = (n >= 2 && n < 12);
      #1;
      if (hold && (phase_done || !r_l)) bad++;
      n++;
      tick();
    end
    hold = 0;
    nchk++;
    if (n != 15) begin nfail++; $display("FAIL hold_r_len: got %0d required %0d", n, 15); end
    nchk++;
    if (bad != 0) begin nfail++; $display("FAIL hold_outputs: got %0d bad cycles required %0d", bad, 0); end
    nchk++;
    if (state !== 6'b000010) begin nfail++; $display("FAIL hold_next: got %b required %b", state, 6'b000010); end
  endtask

  task automatic test_emg();
    bit ok;
    int n = 0;
    do_reset();
    wait_state(P_GF, ok);
    tick();
    emg = 1; tick(); emg = 0;
    #1;
    nchk++;
    if ({state, r_l, g_l, y_l} !== 9'b100000_100) begin
      nfail++; $display("FAIL emg_allred: got %b required %b", {state, r_l, g_l, y_l}, 9'b100000100);
    end
    tick();
    nchk++;
    if (state !== 6'b010000) begin nfail++; $display("FAIL emg_to_r: got %b required %b", state, 6'b010000); end
    while (state[P_R] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 5) begin nfail++; $display("FAIL emg_r_len: got %0d required %0d", n, 5); end
    nchk++;
    if (state !== 6'b000010) begin nfail++; $display("FAIL emg_then_g: got %b required %b", state, 6'b000010); end
  endtask

  task automatic test_emg_hold_zero();
    bit ok;
    int n = 0;
    do_reset();
    wait_state(P_Y, ok);
    emg = 1; hold = 1; tick(); emg = 0; hold = 0;
    #1;
    nchk++;
    if (state !== 6'b100000) begin nfail++; $display("FAIL emg_over_hold: got %b required %b", state, 6'b100000); end
    cfg_we = 1; cfg_sel = 2'd0; cfg_data = '0; tick(); cfg_we = 0;
    while (state[P_R] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 5) begin nfail++; $display("FAIL zero_r_len: got %0d required %0d", n, 5); end
    n = 0;
    while (state[P_G] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 1) begin nfail++; $display("FAIL zero_g_len: got %0d required %0d", n, 1); end
    nchk++;
    if (state !== 6'b000100) begin nfail++; $display("FAIL zero_then_gf: got %b required %b", state, 6'b000100); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n = 0;
    wait_state(P_Y, ok);
    tick();
    #2;
    reset = 0;
    #1;
    nchk++;
    if ({state, phase_done, r_l, g_l, y_l} !== 10'b000001_0_010) begin
      nfail++; $display("FAIL async_reset: got %b required %b", {state, phase_done, r_l, g_l, y_l}, 10'b0000010010);
    end
    m_reset();
    @(negedge clk);
    reset = 1;
    while (state[P_INIT] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 8) begin nfail++; $display("FAIL rst_init_len: got %0d required %0d", n, 8); end
    n = 0;
    while (state[P_G] && n < 40) begin n++; tick(); end
    nchk++;
    if (n != 4) begin nfail++; $display("FAIL rst_g_default: got %0d required %0d", n, 4); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cfg_we   = ($urandom_range(7) == 0);
      cfg_sel  = 2'($urandom_range(3));
      cfg_data = CW'($urandom_range(15));
      hold     = ($urandom_range(5) == 0);
      emg      = ($urandom_range(24) == 0);
      #1;
      nchk++;
      if ({state, phase_done, r_l, g_l, y_l} !== exp_vec()) begin
        nfail++; $display("FAIL random cyc %0d: got %b required %b", c, {state, phase_done, r_l, g_l, y_l}, exp_vec());
      end
      tick();
    end
    cfg_we = 0; hold = 0; emg = 0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_cfg_write();
    test_hold();
    test_emg();
    test_emg_hold_zero();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
